// File: rtl/alu_rs_if.sv
// Issue, CDB snoop and ALU-side output bundle of the ALU reservation station.
// master = issue/CDB/ALU environment, slave = reservation station.
interface alu_rs_if #(
    parameter int unsigned TAG_W = 4
);
    logic             issue_valid;
    logic             issue_ready;
    logic [9:0]       issue_op;
    logic [31:0]      issue_vj;
    logic [TAG_W-1:0] issue_qj;
    logic             issue_qj_pend;
    logic [31:0]      issue_vk;
    logic [TAG_W-1:0] issue_qk;
    logic             issue_qk_pend;
    logic [TAG_W-1:0] issue_dest;

    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_value;

    logic             out_valid;
    logic             out_ready;
    logic [9:0]       out_op;
    logic [31:0]      out_vj;
    logic [31:0]      out_vk;
    logic [TAG_W-1:0] out_dest;

    modport master (
        output issue_valid, issue_op, issue_vj, issue_qj, issue_qj_pend,
        output issue_vk, issue_qk, issue_qk_pend, issue_dest,
        input  issue_ready,
        output cdb_valid, cdb_tag, cdb_value,
        input  out_valid, out_op, out_vj, out_vk, out_dest,
        output out_ready
    );

    modport slave (
        input  issue_valid, issue_op, issue_vj, issue_qj, issue_qj_pend,
        input  issue_vk, issue_qk, issue_qk_pend, issue_dest,
        output issue_ready,
        input  cdb_valid, cdb_tag, cdb_value,
        output out_valid, out_op, out_vj, out_vk, out_dest,
        input  out_ready
    );
endinterface

// File: rtl/alu_rs.sv
// Reservation station for the integer ALU: holds issued ops until both operands are
// captured (at issue or by CDB snoop), then dispatches the lowest ready entry into a register stage.
module alu_rs #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    flush,
    alu_rs_if.slave bus
);
    localparam int unsigned IdxW = $clog2(DEPTH);

    logic [DEPTH-1:0] busy_q, busy_d, rj_q, rj_d, rk_q, rk_d;
    logic [9:0]       op_q   [DEPTH];
    logic [9:0]       op_d   [DEPTH];
    logic [31:0]      vj_q   [DEPTH];
    logic [31:0]      vj_d   [DEPTH];
    logic [31:0]      vk_q   [DEPTH];
    logic [31:0]      vk_d   [DEPTH];
    logic [TAG_W-1:0] qj_q   [DEPTH];
    logic [TAG_W-1:0] qj_d   [DEPTH];
    logic [TAG_W-1:0] qk_q   [DEPTH];
    logic [TAG_W-1:0] qk_d   [DEPTH];
    logic [TAG_W-1:0] dest_q [DEPTH];
    logic [TAG_W-1:0] dest_d [DEPTH];

    logic             out_valid_q, out_valid_d;
    logic [9:0]       out_op_q, out_op_d;
    logic [31:0]      out_vj_q, out_vj_d;
    logic [31:0]      out_vk_q, out_vk_d;
    logic [TAG_W-1:0] out_dest_q, out_dest_d;

    logic [DEPTH-1:0] elig;
    logic [IdxW-1:0]  free_idx, sel_idx;
    logic             any_free, any_elig, can_load, issue_fire;

    // Eligibility and free slots come from registered state only, so a same-cycle
    // wakeup or dispatch never feeds back into issue_ready or selection.
    assign elig       = busy_q & rj_q & rk_q;
    assign any_free   = ~&busy_q;
    assign any_elig   = |elig;
    assign can_load   = !out_valid_q || bus.out_ready;
    assign issue_fire = bus.issue_valid && any_free;

    always_comb begin
        free_idx = '0;
        sel_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy_q[i]) free_idx = IdxW'(i);
            if (elig[i])    sel_idx  = IdxW'(i);
        end
    end

    always_comb begin
        busy_d      = busy_q;
        rj_d        = rj_q;
        rk_d        = rk_q;
        op_d        = op_q;
        vj_d        = vj_q;
        vk_d        = vk_q;
        qj_d        = qj_q;
        qk_d        = qk_q;
        dest_d      = dest_q;
        out_valid_d = out_valid_q;
        out_op_d    = out_op_q;
        out_vj_d    = out_vj_q;
        out_vk_d    = out_vk_q;
        out_dest_d  = out_dest_q;

        for (int i = 0; i < DEPTH; i++) begin
            if (busy_q[i] && bus.cdb_valid) begin
                if (!rj_q[i] && qj_q[i] == bus.cdb_tag) begin
                    vj_d[i] = bus.cdb_value;
                    rj_d[i] = 1'b1;
                end
                if (!rk_q[i] && qk_q[i] == bus.cdb_tag) begin
                    vk_d[i] = bus.cdb_value;
                    rk_d[i] = 1'b1;
                end
            end
        end

        if (can_load) begin
            out_valid_d = any_elig;
            if (any_elig) begin
                out_op_d         = op_q[sel_idx];
                out_vj_d         = vj_q[sel_idx];
                out_vk_d         = vk_q[sel_idx];
                out_dest_d       = dest_q[sel_idx];
                busy_d[sel_idx]  = 1'b0;
            end
        end

        // The free slot is never the dispatched one, so both writes can coexist.
        if (issue_fire) begin
            busy_d[free_idx] = 1'b1;
            op_d[free_idx]   = bus.issue_op;
            dest_d[free_idx] = bus.issue_dest;
            qj_d[free_idx]   = bus.issue_qj;
            qk_d[free_idx]   = bus.issue_qk;
            vj_d[free_idx]   = bus.issue_vj;
            vk_d[free_idx]   = bus.issue_vk;
            rj_d[free_idx]   = !bus.issue_qj_pend;
            rk_d[free_idx]   = !bus.issue_qk_pend;
            if (bus.issue_qj_pend && bus.cdb_valid && bus.cdb_tag == bus.issue_qj) begin
                vj_d[free_idx] = bus.cdb_value;
                rj_d[free_idx] = 1'b1;
            end
            if (bus.issue_qk_pend && bus.cdb_valid && bus.cdb_tag == bus.issue_qk) begin
                vk_d[free_idx] = bus.cdb_value;
                rk_d[free_idx] = 1'b1;
            end
        end

        if (flush) begin
            busy_d      = '0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q      <= '0;
            rj_q        <= '0;
            rk_q        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]   <= '0;
                vj_q[i]   <= '0;
                vk_q[i]   <= '0;
                qj_q[i]   <= '0;
                qk_q[i]   <= '0;
                dest_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_op_q    <= '0;
            out_vj_q    <= '0;
            out_vk_q    <= '0;
            out_dest_q  <= '0;
        end else begin
            busy_q      <= busy_d;
            rj_q        <= rj_d;
            rk_q        <= rk_d;
            op_q        <= op_d;
            vj_q        <= vj_d;
            vk_q        <= vk_d;
            qj_q        <= qj_d;
            qk_q        <= qk_d;
            dest_q      <= dest_d;
            out_valid_q <= out_valid_d;
            out_op_q    <= out_op_d;
            out_vj_q    <= out_vj_d;
            out_vk_q    <= out_vk_d;
            out_dest_q  <= out_dest_d;
        end
    end

    assign bus.issue_ready = any_free;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_op      = out_op_q;
    assign bus.out_vj      = out_vj_q;
    assign bus.out_vk      = out_vk_q;
    assign bus.out_dest    = out_dest_q;
endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: vector table plus hand sequences, with a scoreboard
// queue of expected ALU-side outputs checked whenever the output stage hands one over.
module tb_alu_rs;
    typedef struct packed {
        logic [9:0]  op;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [3:0]  dest;
    } out_t;

    typedef struct {
        logic [9:0]  op;
        logic [31:0] vj;
        logic [3:0]  qj;
        bit          jp;
        logic [31:0] vk;
        logic [3:0]  qk;
        bit          kp;
        logic [3:0]  dest;
        logic [31:0] wj;
        logic [31:0] wk;
    } vec_t;

    localparam int NV = 6;

    logic clk, reset, flush;
    int   n_checks = 0;
    int   n_fail   = 0;
    out_t sb[$];
    vec_t vecs[NV];

    alu_rs_if #(.TAG_W(4)) bus ();

    alu_rs #(.DEPTH(4), .TAG_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic drive_issue(input logic [9:0] op, input logic [31:0] vj, input logic [3:0] qj,
                               input bit jp, input logic [31:0] vk, input logic [3:0] qk,
                               input bit kp, input logic [3:0] dest);
        bus.issue_valid   = 1'b1;
        bus.issue_op      = op;
        bus.issue_vj      = vj;
        bus.issue_qj      = qj;
        bus.issue_qj_pend = jp;
        bus.issue_vk      = vk;
        bus.issue_qk      = qk;
        bus.issue_qk_pend = kp;
        bus.issue_dest    = dest;
    endtask

    task automatic cdb(input bit v, input logic [3:0] tag, input logic [31:0] value);
        bus.cdb_valid = v;
        bus.cdb_tag   = tag;
        bus.cdb_value = value;
    endtask

    task automatic push(input logic [9:0] op, input logic [31:0] vj, input logic [31:0] vk,
                        input logic [3:0] dest);
        out_t e;
        e.op   = op;
        e.vj   = vj;
        e.vk   = vk;
        e.dest = dest;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 30) begin
            step();
            n++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d outputs never appeared, required 0 outstanding", name, sb.size());
            sb.delete();
        end
    endtask

    // Scoreboard: an output beat is consumed at the next edge when valid and ready.
    always @(negedge clk) begin : monitor
        out_t exp_o;
        out_t act_o;
        if (!reset && !flush && bus.out_valid && bus.out_ready) begin
            n_checks++;
            act_o = {bus.out_op, bus.out_vj, bus.out_vk, bus.out_dest};
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL out_unexpected: got op=%h vj=%h vk=%h dest=%h, required no output",
                         act_o.op, act_o.vj, act_o.vk, act_o.dest);
            end else begin
                exp_o = sb.pop_front();
                if (act_o !== exp_o) begin
                    n_fail++;
                    $display("FAIL out_beat: got op=%h vj=%h vk=%h dest=%h, required op=%h vj=%h vk=%h dest=%h",
                             act_o.op, act_o.vj, act_o.vk, act_o.dest,
                             exp_o.op, exp_o.vj, exp_o.vk, exp_o.dest);
                end
            end
        end
    end

    initial begin
        // op, vj, qj, jp, vk, qk, kp, dest, wake_j, wake_k
        vecs[0] = '{10'h3FF, 32'hFFFF_FFFF, 4'd0, 1'b0, 32'h0, 4'd0, 1'b0, 4'hF, 32'h0, 32'h0};
        vecs[1] = '{10'h011, 32'hBAD, 4'd2, 1'b1, 32'd9, 4'd0, 1'b0, 4'd1, 32'h10, 32'h0};
        vecs[2] = '{10'h222, 32'h1111, 4'd0, 1'b0, 32'hBAD, 4'd6, 1'b1, 4'd2, 32'h0, 32'h1234_5678};
        vecs[3] = '{10'h0C7, 32'hBAD, 4'd7, 1'b1, 32'hBAD, 4'd7, 1'b1, 4'd3, 32'hCAFE_0007, 32'h0};
        vecs[4] = '{10'h155, 32'hBAD, 4'd8, 1'b1, 32'hBAD, 4'd9, 1'b1, 4'd4, 32'h80, 32'h90};
        vecs[5] = '{10'h2AA, 32'hBAD, 4'd3, 1'b1, 32'h77, 4'd3, 1'b0, 4'd5, 32'h999, 32'h0};

        reset = 1'b1;
        flush = 1'b0;
        bus.issue_valid = 1'b0;
        drive_issue(10'h0, 32'h0, 4'd0, 1'b0, 32'h0, 4'd0, 1'b0, 4'd0);
        bus.issue_valid = 1'b0;
        cdb(1'b0, 4'd0, 32'h0);
        bus.out_ready = 1'b0;
        repeat (2) step();
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_issue_ready", 32'(bus.issue_ready), 1);
        reset = 1'b0;
        step();

        // Reset mid-operation: one op in the output stage, three entries busy.
        for (int i = 0; i < 4; i++) begin
            drive_issue(10'(i + 1), 32'(8'h11 * (i + 1)), 4'd0, 1'b0, 32'h99, 4'd0, 1'b0, 4'(i + 1));
            step();
        end
        bus.issue_valid = 1'b0;
        check("midrst_setup_valid", 32'(bus.out_valid), 1);
        check("midrst_setup_vj", bus.out_vj, 32'h11);
        #1 reset = 1'b1;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 0);
        check("midrst_issue_ready", 32'(bus.issue_ready), 1);
        check("midrst_out_op", 32'(bus.out_op), 0);
        check("midrst_out_vj", bus.out_vj, 0);
        check("midrst_out_vk", bus.out_vk, 0);
        check("midrst_out_dest", 32'(bus.out_dest), 0);
        step();
        reset = 1'b0;
        step();
        sb.delete();

        // Two-edge latency for an op with both operands ready.
        bus.out_ready = 1'b1;
        push(10'h000, 32'd5, 32'd7, 4'd3);
        drive_issue(10'h000, 32'd5, 4'd0, 1'b0, 32'd7, 4'd0, 1'b0, 4'd3);
        step();
        bus.issue_valid = 1'b0;
        check("lat_e0_valid", 32'(bus.out_valid), 0);
        step();
        check("lat_e1_valid", 32'(bus.out_valid), 1);
        check("lat_e1_vj", bus.out_vj, 32'd5);
        check("lat_e1_dest", 32'(bus.out_dest), 3);
        wait_drain("lat_drain");
        step();
        check("lat_idle_valid", 32'(bus.out_valid), 0);

        // Issue-time CDB bypass of a pending k operand.
        push(10'h02A, 32'h1234, 32'hABCD, 4'd4);
        drive_issue(10'h02A, 32'h1234, 4'd0, 1'b0, 32'h0, 4'd6, 1'b1, 4'd4);
        cdb(1'b1, 4'd6, 32'hABCD);
        step();
        bus.issue_valid = 1'b0;
        cdb(1'b0, 4'd0, 32'h0);
        check("byp_e0_valid", 32'(bus.out_valid), 0);
        step();
        check("byp_e1_valid", 32'(bus.out_valid), 1);
        check("byp_e1_vk", bus.out_vk, 32'hABCD);
        wait_drain("byp_drain");
        step();

        for (int i = 0; i < NV; i++) begin
            vec_t v;
            logic [31:0] ej, ek;
            v  = vecs[i];
            ej = v.jp ? v.wj : v.vj;
            ek = v.kp ? ((v.jp && v.qk == v.qj) ? v.wj : v.wk) : v.vk;
            push(v.op, ej, ek, v.dest);
            drive_issue(v.op, v.vj, v.qj, v.jp, v.vk, v.qk, v.kp, v.dest);
            step();
            bus.issue_valid = 1'b0;
            if (v.jp || v.kp) begin
                cdb(1'b1, 4'd5, 32'hDEAD_BEEF);
                step();
                cdb(1'b0, 4'd0, 32'h0);
                step();
                check($sformatf("vec%0d_wait_valid", i), 32'(bus.out_valid), 0);
                if (v.jp) begin
                    cdb(1'b1, v.qj, v.wj);
                    step();
                end
                if (v.kp && !(v.jp && v.qk == v.qj)) begin
                    cdb(1'b1, v.qk, v.wk);
                    step();
                end
                cdb(1'b0, 4'd0, 32'h0);
            end
            wait_drain($sformatf("vec%0d_drain", i));
            step();
        end

        // Fill all entries with waiting ops; a fifth issue waits for a freed slot.
        for (int i = 0; i < 4; i++) begin
            drive_issue(10'(12'h100 + i), 32'hBAD, 4'(i + 1), 1'b1, 32'(100 + i), 4'd0, 1'b0, 4'(i));
            step();
        end
        check("full_ready", 32'(bus.issue_ready), 0);
        drive_issue(10'h005, 32'h55, 4'd0, 1'b0, 32'h66, 4'd0, 1'b0, 4'd9);
        step();
        check("full_ignored_ready", 32'(bus.issue_ready), 0);
        check("full_ignored_valid", 32'(bus.out_valid), 0);
        push(10'h101, 32'h222, 32'd101, 4'd1);
        cdb(1'b1, 4'd2, 32'h222);
        step();
        cdb(1'b0, 4'd0, 32'h0);
        check("full_woken_ready", 32'(bus.issue_ready), 0);
        push(10'h005, 32'h55, 32'h66, 4'd9);
        step();
        check("full_disp_valid", 32'(bus.out_valid), 1);
        check("full_freed_ready", 32'(bus.issue_ready), 1);
        step();
        bus.issue_valid = 1'b0;
        check("full_refill_ready", 32'(bus.issue_ready), 0);
        step();
        check("full_fifth_dest", 32'(bus.out_dest), 9);
        for (int t = 1; t <= 4; t++) begin
            if (t != 2) begin
                push(10'(12'h100 + t - 1), 32'(16'h1000 * t), 32'(100 + t - 1), 4'(t - 1));
                cdb(1'b1, 4'(t), 32'(16'h1000 * t));
                step();
            end
        end
        cdb(1'b0, 4'd0, 32'h0);
        wait_drain("full_drain");
        step();

        // Output stage stall, then flush.
        bus.out_ready = 1'b0;
        drive_issue(10'h3C1, 32'hAAAA_0001, 4'd0, 1'b0, 32'hBBBB_0001, 4'd0, 1'b0, 4'd7);
        step();
        for (int i = 0; i < 4; i++) begin
            drive_issue(10'(12'h040 + i), 32'(i), 4'd0, 1'b0, 32'(i), 4'd0, 1'b0, 4'(8 + i));
            step();
        end
        bus.issue_valid = 1'b0;
        check("hold_setup_valid", 32'(bus.out_valid), 1);
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("hold%0d_valid", c), 32'(bus.out_valid), 1);
            check($sformatf("hold%0d_op", c), 32'(bus.out_op), 32'h3C1);
            check($sformatf("hold%0d_vj", c), bus.out_vj, 32'hAAAA_0001);
            check($sformatf("hold%0d_vk", c), bus.out_vk, 32'hBBBB_0001);
            check($sformatf("hold%0d_dest", c), 32'(bus.out_dest), 7);
            check($sformatf("hold%0d_ready", c), 32'(bus.issue_ready), 0);
        end
        flush = 1'b1;
        bus.out_ready = 1'b1;
        step();
        flush = 1'b0;
        check("flush_out_valid", 32'(bus.out_valid), 0);
        check("flush_issue_ready", 32'(bus.issue_ready), 1);
        step();
        check("flush_empty_valid", 32'(bus.out_valid), 0);

        // Flush wins over a same-cycle issue.
        drive_issue(10'h0F0, 32'h1, 4'd0, 1'b0, 32'h2, 4'd0, 1'b0, 4'd6);
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.issue_valid = 1'b0;
        step();
        check("flush_issue_dropped", 32'(bus.out_valid), 0);
        step();

        check("sb_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
